// File: rtl/proc_run_ctrl_pkg.sv
// rtl/proc_run_ctrl_pkg.sv - shared state encoding and defaults for the run/load sequencer
// Purpose: state enum used by proc_run_ctrl and anything decoding its state output.
// Ports: none (package).
package proc_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_HALTED    = 3'd4,
    ST_STEP      = 3'd5,
    ST_STEP_WAIT = 3'd6
  } run_state_e;

  // Cycles Run stays low so the longest instruction (T0..T5) settles back in T0.
  localparam int QUIESCE_DEFAULT = 5;
  localparam int ADDR_W_DEFAULT  = 16;

endpackage

// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - run/load sequencer owning processor Run, reset and the memory port
// Purpose: loads a program image while the processor is in reset, then runs, halts
//          (command or watchpoint) and single-steps it.
// Ports:
//   Clock, Resetn                 clock and synchronous active-low reset
//   ld_start/ld_count             begin a load of ld_count words at address 0
//   ld_valid/ld_data/ld_ready     program word stream, transfer on valid & ready
//   go/halt/mode_step/step        execution control pulses
//   brk_en/brk_addr               address watchpoint
//   proc_addr/proc_dout/proc_w    processor memory request
//   proc_run/proc_resetn          processor control lines
//   mem_addr/mem_data/mem_wren    memory port
//   brk_hit, state                status
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int QUIESCE = QUIESCE_DEFAULT
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        ld_start,
  input  logic [15:0] ld_count,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  input  logic        go,
  input  logic        halt,
  input  logic        mode_step,
  input  logic        step,
  input  logic        brk_en,
  input  logic [15:0] brk_addr,
  input  logic [15:0] proc_addr,
  input  logic [15:0] proc_dout,
  input  logic        proc_w,
  output logic        proc_run,
  output logic        proc_resetn,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  output logic        brk_hit,
  output logic [2:0]  state
);

  localparam int QW = $clog2(QUIESCE + 1);

  run_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [15:0]       remain_q, remain_d;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic              match_q, match_d;
  logic              brk_hit_q, brk_hit_d;
  logic              hit;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      remain_q  <= '0;
      qcnt_q    <= '0;
      match_q   <= 1'b0;
      brk_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      remain_q  <= remain_d;
      qcnt_q    <= qcnt_d;
      match_q   <= match_d;
      brk_hit_q <= brk_hit_d;
    end
  end

  // Only the rising edge of a match stops the processor, so resuming while
  // ADDR still sits on the watch address does not immediately re-trigger.
  assign match_d = brk_en & (proc_addr == brk_addr);
  assign hit     = match_d & ~match_q;

  assign state   = state_q;
  assign brk_hit = brk_hit_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    remain_d    = remain_q;
    qcnt_d      = qcnt_q;
    brk_hit_d   = brk_hit_q;
    proc_run    = 1'b0;
    proc_resetn = 1'b1;
    ld_ready    = 1'b0;
    mem_addr    = proc_addr;
    mem_data    = proc_dout;
    mem_wren    = proc_w;

    case (state_q)
      ST_IDLE: begin
        proc_resetn = 1'b0;
        // Processor is in reset, so the port is parked rather than passed through.
        mem_addr    = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (ld_start && (ld_count != 16'd0)) begin
          state_d  = ST_LOAD;
          wcnt_d   = '0;
          remain_d = ld_count;
        end else if (go) begin
          state_d = mode_step ? ST_HALTED : ST_RUN;
        end
      end

      ST_LOAD: begin
        proc_resetn = 1'b0;
        ld_ready    = 1'b1;
        mem_addr    = 16'(wcnt_q);
        mem_data    = ld_data;
        mem_wren    = ld_valid;
        if (ld_valid) begin
          wcnt_d   = wcnt_q + ADDR_W'(1);
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        proc_run = 1'b1;
        if (halt || hit) begin
          state_d = ST_DRAIN;
          qcnt_d  = QW'(QUIESCE - 1);
        end
        if (hit) begin
          brk_hit_d = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (qcnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          qcnt_d = qcnt_q - QW'(1);
        end
      end

      ST_HALTED: begin
        if (ld_start && (ld_count != 16'd0)) begin
          state_d  = ST_LOAD;
          wcnt_d   = '0;
          remain_d = ld_count;
        end else if (go) begin
          brk_hit_d = 1'b0;
          if (!mode_step) begin
            state_d = ST_RUN;
          end
        end else if (step) begin
          brk_hit_d = 1'b0;
          state_d   = ST_STEP;
        end
      end

      ST_STEP: begin
        proc_run = 1'b1;
        state_d  = ST_STEP_WAIT;
        qcnt_d   = QW'(QUIESCE - 1);
      end

      ST_STEP_WAIT: begin
        if (qcnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          qcnt_d = qcnt_q - QW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb/tb_proc_run_ctrl.sv - self-checking bench for the run/load sequencer
module tb_proc_run_ctrl;
  import proc_run_ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        ld_start = 1'b0;
  logic [15:0] ld_count = '0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic        go = 1'b0;
  logic        halt = 1'b0;
  logic        mode_step = 1'b0;
  logic        step = 1'b0;
  logic        brk_en = 1'b0;
  logic [15:0] brk_addr = '0;
  logic [15:0] proc_addr = '0;
  logic [15:0] proc_dout = '0;
  logic        proc_w = 1'b0;
  logic        proc_run;
  logic        proc_resetn;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic        brk_hit;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  // Expected memory writes as {addr, data}, pushed when stimulus is driven.
  logic [31:0] exp_q[$];

  proc_run_ctrl #(.ADDR_W(16), .QUIESCE(5)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .ld_start(ld_start), .ld_count(ld_count), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .go(go), .halt(halt), .mode_step(mode_step), .step(step),
    .brk_en(brk_en), .brk_addr(brk_addr), .proc_addr(proc_addr), .proc_dout(proc_dout),
    .proc_w(proc_w), .proc_run(proc_run), .proc_resetn(proc_resetn),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .brk_hit(brk_hit), .state(state)
  );

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Scoreboard: every memory write must match the head of the expected queue.
  always @(negedge Clock) begin
    if (mem_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write_unexpected: got addr=%h data=%h, expected no write", mem_addr, mem_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_data, e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (state !== ST_HALTED && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (state !== ST_HALTED) begin
      errors++;
      $display("FAIL %s_wait_halted: state=%0d, expected %0d", name, state, ST_HALTED);
    end
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    proc_addr = 16'h5A5A;
    proc_dout = 16'hA5A5;
    tick();
    tick();
    checks++;
    if ({state, proc_run, proc_resetn, ld_ready, mem_wren, brk_hit} !== {ST_IDLE, 5'b00000}) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d run=%b rstn=%b rdy=%b wren=%b brk=%b, expected 0 and all zero",
               state, proc_run, proc_resetn, ld_ready, mem_wren, brk_hit);
    end
    checks++;
    if ({mem_addr, mem_data} !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: addr=%h data=%h, expected 0000 0000", mem_addr, mem_data);
    end
    Resetn = 1'b1;
    proc_addr = '0;
    proc_dout = '0;
    tick();
  endtask

  task automatic do_load(input string name, input logic [15:0] words[$], input int gap_mask);
    int sent = 0;
    int cyc = 0;
    ld_start = 1'b1;
    ld_count = 16'(words.size());
    tick();
    ld_start = 1'b0;
    ld_count = '0;
    while (sent < words.size() && cyc < 32) begin
      checks++;
      if (state !== ST_LOAD || ld_ready !== 1'b1 || proc_resetn !== 1'b0) begin
        errors++;
        $display("FAIL %s_in_load: state=%0d rdy=%b rstn=%b, expected 1 1 0", name, state, ld_ready, proc_resetn);
      end
      if (gap_mask[cyc % 32]) begin
        ld_valid = 1'b0;
        ld_data = 16'hDEAD;
      end else begin
        ld_valid = 1'b1;
        ld_data = words[sent];
        exp_q.push_back({16'(sent), words[sent]});
        sent++;
      end
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    checks++;
    if (state !== ST_IDLE || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: state=%0d rdy=%b, expected 0 0", name, state, ld_ready);
    end
  endtask

  task automatic test_load;
    logic [15:0] w[$];
    w = '{16'h1000, 16'h3001, 16'h5002, 16'h7003};
    do_load("load4", w, 32'b1_0010);
  endtask

  task automatic test_load_zero;
    ld_start = 1'b1;
    ld_count = 16'd0;
    ld_valid = 1'b1;
    ld_data = 16'hBAD0;
    tick();
    ld_start = 1'b0;
    checks++;
    if (state !== ST_IDLE || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_zero: state=%0d rdy=%b, expected 0 0", state, ld_ready);
    end
    tick();
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic test_run_halt;
    int n = 0;
    mode_step = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if (state !== ST_RUN || proc_run !== 1'b1 || proc_resetn !== 1'b1) begin
      errors++;
      $display("FAIL go_run: state=%0d run=%b rstn=%b, expected 2 1 1", state, proc_run, proc_resetn);
    end
    proc_addr = 16'h1234;
    proc_dout = 16'hBEEF;
    proc_w = 1'b1;
    exp_q.push_back({16'h1234, 16'hBEEF});
    #1;
    checks++;
    if (mem_addr !== 16'h1234 || mem_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL passthrough: addr=%h data=%h, expected 1234 beef", mem_addr, mem_data);
    end
    tick();
    proc_w = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    while (state === ST_DRAIN && n < 20) begin
      checks++;
      if (proc_run !== 1'b0) begin
        errors++;
        $display("FAIL drain_run: run=%b, expected 0", proc_run);
      end
      tick();
      n++;
    end
    checks++;
    if (n !== 5 || state !== ST_HALTED) begin
      errors++;
      $display("FAIL drain_len: cycles=%0d state=%0d, expected 5 and 4", n, state);
    end
  endtask

  task automatic test_watchpoint;
    brk_en = 1'b1;
    brk_addr = 16'h0003;
    proc_addr = 16'h0000;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int a = 0; a < 4; a++) begin
      proc_addr = 16'(a);
      tick();
      checks++;
      if (a < 3 && state !== ST_RUN) begin
        errors++;
        $display("FAIL brk_early: addr=%0d state=%0d, expected 2", a, state);
      end else if (a == 3 && (state !== ST_DRAIN || brk_hit !== 1'b1)) begin
        errors++;
        $display("FAIL brk_hit: state=%0d brk=%b, expected 3 1", state, brk_hit);
      end
    end
    wait_halted("brk");
    checks++;
    if (brk_hit !== 1'b1) begin
      errors++;
      $display("FAIL brk_sticky: brk=%b, expected 1", brk_hit);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== ST_RUN || brk_hit !== 1'b0) begin
        errors++;
        $display("FAIL brk_resume: cycle=%0d state=%0d brk=%b, expected 2 0", i, state, brk_hit);
      end
      tick();
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    wait_halted("brk_stop");
    brk_en = 1'b0;
  endtask

  task automatic test_step;
    int runs = 0;
    run_state_e seq[7];
    seq = '{ST_STEP, ST_STEP_WAIT, ST_STEP_WAIT, ST_STEP_WAIT, ST_STEP_WAIT, ST_STEP_WAIT, ST_HALTED};
    mode_step = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if (state !== ST_HALTED || proc_run !== 1'b0) begin
      errors++;
      $display("FAIL step_go: state=%0d run=%b, expected 4 0", state, proc_run);
    end
    for (int c = 0; c < 12; c++) begin
      step = (c == 0 || c == 2 || c == 4);
      tick();
      if (proc_run === 1'b1) runs++;
    end
    step = 1'b0;
    checks++;
    if (runs !== 1 || state !== ST_HALTED) begin
      errors++;
      $display("FAIL step_burst: run_cycles=%0d state=%0d, expected 1 and 4", runs, state);
    end
    step = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      step = 1'b0;
      checks++;
      if (state !== seq[c] || proc_run !== (seq[c] == ST_STEP)) begin
        errors++;
        $display("FAIL step_seq: cycle=%0d state=%0d run=%b, expected %0d %b",
                 c, state, proc_run, seq[c], seq[c] == ST_STEP);
      end
    end
    mode_step = 1'b0;
  endtask

  task automatic test_reset_mid_load;
    logic [15:0] w[$];
    ld_start = 1'b1;
    ld_count = 16'd5;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data = 16'hC000 + 16'(i);
      exp_q.push_back({16'(i), 16'hC000 + 16'(i)});
      tick();
    end
    ld_valid = 1'b0;
    checks++;
    if (state !== ST_LOAD) begin
      errors++;
      $display("FAIL partial_load: state=%0d, expected 1", state);
    end
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    checks++;
    if (state !== ST_IDLE || ld_ready !== 1'b0 || proc_resetn !== 1'b0 || proc_run !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_load: state=%0d rdy=%b rstn=%b run=%b, expected 0 0 0 0",
               state, ld_ready, proc_resetn, proc_run);
    end
    w = '{16'hAAAA, 16'h5555};
    do_load("reload", w, 32'b0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_zero();
    test_run_halt();
    test_watchpoint();
    test_step();
    test_reset_mid_load();
    tick();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL writes_missing: %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
